rv32_fetch_stage: RTL
=====================

Name: rv32_fetch_stage

Overview:
- Instruction fetch stage. Sits upstream of decode and downstream of the execute-stage branch resolution; it consumes the taken-branch/jump redirect driven from do_branch and the computed target.
- Owns the architectural PC and issues word requests to instruction memory over a valid/ready request channel with a fixed-order response channel.
- Presents fetched instructions to decode over a valid/ready handshake. Kills wrong-path fetches on redirect.
- At most one memory request is outstanding at any time.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  32  word-aligned fetch address (rv32_word).
- imem_resp_valid  input  1  response data valid; in order, one per accepted request, at least 1 cycle after acceptance.
- imem_resp_data  input  32  instruction word.
- redirect_valid  input  1  taken branch/jump from execute (do_branch qualified by a valid instruction).
- redirect_pc  input  32  branch/jump target.
- out_valid  output  1  instruction valid to decode.
- out_ready  input  1  decode accepts.
- out_instr  output  32  instruction word.
- out_pc  output  32  PC of out_instr.
- misalign_err  output  1  one-cycle pulse: redirect_pc[1:0] != 0.

Behaviour:
- Reset (rst=1 at a clock edge): pc=RESET_PC, state=REQ, drop=0, out_valid=0, out_instr=0, out_pc=0, misalign_err=0, imem_req_valid=0 during any cycle where rst=1.
- imem_req_valid=1 only in REQ. imem_req_addr=pc, driven combinationally from the pc register.
- FSM states:
  - REQ: on imem_req_valid & imem_req_ready, latch inflight_pc=pc and go to WAIT.
  - WAIT: on imem_resp_valid with drop=0, load out_instr/out_pc(=inflight_pc), set out_valid=1, pc=inflight_pc+4, go to HOLD. With drop=1, discard the data, clear drop, go to REQ.
  - HOLD: out_valid held stable with out_instr/out_pc unchanged until out_ready. On out_valid & out_ready, clear out_valid and go to REQ.
- Latency: accept edge to out_valid is 1 cycle after resp_valid. Throughput is one instruction per 3 cycles minimum with zero-wait memory (no overlap by design).
- Redirect (redirect_valid=1) has top priority over all other events in the same cycle:
  - pc = {redirect_pc[31:2],2'b00}; out_valid is cleared, so a held instruction is flushed even if out_ready=1.
  - misalign_err = |redirect_pc[1:0] for exactly that cycle.
  - In REQ with the request handshake in the same cycle: the old-path request is already accepted; go to WAIT with drop=1.
  - In REQ without handshake: stay in REQ; the next request uses the new pc.
  - In WAIT with no response this cycle: stay in WAIT with drop=1.
  - In WAIT with a response in the same cycle: discard the response; go to REQ with drop=0.
  - In HOLD: go to REQ.
- Redirects on consecutive cycles: the last one wins; drop stays 1 while a request is outstanding (only one is ever outstanding).
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- Responses arriving in REQ or HOLD are protocol violations; ignore them (assertion in the bench).

Decomposition:
- Shared package rv32_pkg:
  - rv32_word typedef (logic [31:0]).
  - INSTR_BYTES = 4.
  - fetch_state_t enum {FS_REQ, FS_WAIT, FS_HOLD}.
- One natural sub-module: rv32_fetch_out_reg, the valid/ready holding register for out_instr/out_pc with a flush input.
- FSM, pc and drop logic live in the top module.

Test Plan:
- Reset then zero-wait memory returning addr^32'hA5A5_A5A5, out_ready=1 -> out_pc sequence 0,4,8 every 3 cycles, out_instr matching the returned data.
- out_ready=0 for 5 cycles with out_valid=1, instr 0x00000013 at pc 0x8 -> out_instr/out_pc stable and no new imem request issued until out_ready rises.
- redirect_valid with redirect_pc=0x100 while in WAIT for pc 0x10, response arriving 2 cycles later -> that response dropped; next imem_req_addr=0x100; out_pc=0x100 is the first out_valid.
- Redirect coincident with the request handshake at pc 0x20 -> 0x20 response discarded, next request is to the target; redirect coincident with resp_valid -> response discarded, no extra drop.
- redirect_pc=0x202 -> misalign_err high for exactly 1 cycle, next imem_req_addr=0x200.
- rst asserted in WAIT and HOLD, and RESET_PC=0xFFFF_FFFC -> all outputs return to reset values; first fetch at 0xFFFF_FFFC, second at 0x0000_0000.

Source files
------------

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared types and helpers for the rv32 fetch stage
package rv32_pkg;

    typedef logic [31:0] rv32_word;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_t;

    function automatic rv32_word word_align(input rv32_word addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv32_fetch_out_reg.sv
// rtl/rv32_fetch_out_reg.sv - valid/ready holding register for the decode-facing instruction
// Flush wins over load and over a same-cycle handshake so a killed instruction never reaches decode.
module rv32_fetch_out_reg
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);

    logic        r_valid;
    rv32_word    r_instr;
    rv32_word    r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/rv32_fetch_stage.sv
// rtl/rv32_fetch_stage.sv - single-outstanding instruction fetch with redirect and wrong-path kill
module rv32_fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        misalign_err
);

    fetch_state_t r_state;
    rv32_word     r_pc;
    rv32_word     r_inflight_pc;
    logic         r_drop;

    logic         w_req_hs;
    logic         w_resp_take;
    logic         w_load;
    logic         w_xfer;
    rv32_word     w_redirect_pc;

    assign imem_req_valid = (r_state == FS_REQ) && !rst;
    assign imem_req_addr  = r_pc;
    assign w_req_hs       = imem_req_valid && imem_req_ready;
    assign w_resp_take    = (r_state == FS_WAIT) && imem_resp_valid;
    assign w_load         = w_resp_take && !r_drop && !redirect_valid;
    assign w_xfer         = out_valid && out_ready;
    assign w_redirect_pc  = word_align(redirect_pc);
    assign misalign_err   = !rst && redirect_valid && (redirect_pc[1:0] != 2'b00);

    // drop marks the single outstanding request as wrong-path; its response is swallowed in WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FS_REQ;
            r_pc          <= RESET_PC;
            r_inflight_pc <= '0;
            r_drop        <= 1'b0;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_pc;
            case (r_state)
                FS_REQ: begin
                    if (w_req_hs) begin
                        r_inflight_pc <= r_pc;
                        r_state       <= FS_WAIT;
                        r_drop        <= 1'b1;
                    end
                end
                FS_WAIT: begin
                    if (imem_resp_valid) begin
                        r_state <= FS_REQ;
                        r_drop  <= 1'b0;
                    end else begin
                        r_drop  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= FS_REQ;
                end
            endcase
        end else begin
            case (r_state)
                FS_REQ: begin
                    if (w_req_hs) begin
                        r_inflight_pc <= r_pc;
                        r_state       <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (w_resp_take) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= FS_REQ;
                        end else begin
                            r_pc    <= r_inflight_pc + INSTR_BYTES;
                            r_state <= FS_HOLD;
                        end
                    end
                end
                FS_HOLD: begin
                    if (w_xfer) begin
                        r_state <= FS_REQ;
                    end
                end
                default: begin
                    r_state <= FS_REQ;
                end
            endcase
        end
    end

    rv32_fetch_out_reg u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_instr (imem_resp_data),
        .i_pc    (r_inflight_pc),
        .i_flush (redirect_valid),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_instr (out_instr),
        .o_pc    (out_pc)
    );

endmodule
